// File: rtl/ex_stage.sv
// ex_stage: RV32I execute stage fed by the ID/EX register.
//   - Single-cycle ALU, branch/jump resolution and store formatting.
//   - Multi-cycle DIV/DIVU/REM/REMU on a restoring divider. hold_ena_o stalls
//     the front end while a division is in flight.
// Optional feature: define EX_MUL_EN for single-cycle MUL/MULH/MULHSU/MULHU.
//   When it is undefined, those encodings suppress write-back and act as NOP.
// Ports:
//   clk_100MHz, rst (synchronous, active-high)
//   inst_i, inst_addr_i, reg1/2_r_data_i, op1/op2_i, op1/op2_jump_i : decoded operands
//   reg_w_ena_i/addr_i, mem_r_ena_i, mem_w_ena_i                      : decoder control
//   reg_w_*_o     : write-back request toward EX/MEM
//   mem_*_o       : load/store request, address, replicated data, byte strobes
//   jump_ena_o/addr_o : flush/redirect
//   hold_ena_o        : stall IF/ID/ID-EX
module ex_stage #(
  parameter int unsigned DIV_ITER = 32
) (
  input  logic        clk_100MHz,
  input  logic        rst,
  input  logic [31:0] inst_i,
  input  logic [31:0] inst_addr_i,
  input  logic [31:0] reg1_r_data_i,
  input  logic [31:0] reg2_r_data_i,
  input  logic        reg_w_ena_i,
  input  logic [4:0]  reg_w_addr_i,
  input  logic        mem_r_ena_i,
  input  logic        mem_w_ena_i,
  input  logic [31:0] op1_i,
  input  logic [31:0] op2_i,
  input  logic [31:0] op1_jump_i,
  input  logic [31:0] op2_jump_i,
  output logic        reg_w_ena_o,
  output logic [4:0]  reg_w_addr_o,
  output logic [31:0] reg_w_data_o,
  output logic        mem_r_ena_o,
  output logic        mem_w_ena_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_w_data_o,
  output logic [3:0]  mem_w_sel_o,
  output logic        jump_ena_o,
  output logic [31:0] jump_addr_o,
  output logic        hold_ena_o
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam int unsigned CNT_W = $clog2(DIV_ITER);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} div_state_e;

  div_state_e state, state_n;

  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  shamt;
  logic [31:0] alu_res, sum_res, jump_add;
  logic        br_taken;

  assign opcode   = inst_i[6:0];
  assign funct3   = inst_i[14:12];
  assign funct7   = inst_i[31:25];
  assign shamt    = op2_i[4:0];
  assign sum_res  = op1_i + op2_i;
  assign jump_add = op1_jump_i + op2_jump_i;

  // Decode of M-extension and divide corner cases
  logic is_mext, div_req, div_signed, div_rem, div_zero, div_ovf, div_start;
  logic [31:0] a_abs, b_abs, corner_res;

  assign is_mext    = (opcode == OPC_OP) && (funct7 == 7'b0000001);
  assign div_req    = is_mext && funct3[2];
  assign div_signed = !funct3[0];
  assign div_rem    = funct3[1];
  assign div_zero   = (op2_i == '0);
  assign div_ovf    = div_signed && (op1_i == 32'h8000_0000) && (op2_i == '1);
  assign div_start  = (state == S_IDLE) && div_req && !div_zero && !div_ovf;
  assign a_abs      = (div_signed && op1_i[31]) ? -op1_i : op1_i;
  assign b_abs      = (div_signed && op2_i[31]) ? -op2_i : op2_i;
  assign corner_res = div_zero ? (div_rem ? op1_i : '1)
                               : (div_rem ? '0 : 32'h8000_0000);

  // Divider datapath registers
  logic [CNT_W-1:0] cnt;
  logic [31:0] quo_q, rem_q, dvs_q;
  logic        q_neg_q, r_neg_q, is_rem_q;
  logic [4:0]  rd_q;

  // Restoring step: quo_q doubles as the dividend shift register; its MSB
  // feeds the partial remainder and the new quotient bit enters at the LSB.
  logic [32:0] r_sh, step_diff;
  logic        step_ge;
  logic [31:0] rem_next, div_res;

  assign r_sh      = {rem_q, quo_q[31]};
  assign step_ge   = (r_sh >= {1'b0, dvs_q});
  assign step_diff = r_sh - {1'b0, dvs_q};
  assign rem_next  = step_ge ? step_diff[31:0] : r_sh[31:0];
  assign div_res   = is_rem_q ? (r_neg_q ? -rem_q : rem_q)
                              : (q_neg_q ? -quo_q : quo_q);

  always_ff @(posedge clk_100MHz) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (div_start) state_n = S_CALC;
      S_CALC:  if (cnt == CNT_W'(DIV_ITER - 1)) state_n = S_DONE;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_100MHz) begin
    if (rst) begin
      cnt      <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      dvs_q    <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      is_rem_q <= 1'b0;
      rd_q     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (div_start) begin
            cnt      <= '0;
            quo_q    <= a_abs;
            rem_q    <= '0;
            dvs_q    <= b_abs;
            q_neg_q  <= div_signed && (op1_i[31] ^ op2_i[31]);
            r_neg_q  <= div_signed && op1_i[31];
            is_rem_q <= div_rem;
            rd_q     <= reg_w_addr_i;
          end
        end
        S_CALC: begin
          quo_q <= {quo_q[30:0], step_ge};
          rem_q <= rem_next;
          cnt   <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // ALU
  always_comb begin
    alu_res = '0;
    case (funct3)
      3'b000: alu_res = ((opcode == OPC_OP) && funct7[5]) ? op1_i - op2_i : sum_res;
      3'b001: alu_res = op1_i << shamt;
      3'b010: alu_res = {31'd0, $signed(op1_i) < $signed(op2_i)};
      3'b011: alu_res = {31'd0, op1_i < op2_i};
      3'b100: alu_res = op1_i ^ op2_i;
      3'b101: alu_res = funct7[5] ? $unsigned($signed(op1_i) >>> shamt) : op1_i >> shamt;
      3'b110: alu_res = op1_i | op2_i;
      3'b111: alu_res = op1_i & op2_i;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    br_taken = 1'b0;
    case (funct3)
      3'b000: br_taken = (reg1_r_data_i == reg2_r_data_i);
      3'b001: br_taken = (reg1_r_data_i != reg2_r_data_i);
      3'b100: br_taken = ($signed(reg1_r_data_i) <  $signed(reg2_r_data_i));
      3'b101: br_taken = ($signed(reg1_r_data_i) >= $signed(reg2_r_data_i));
      3'b110: br_taken = (reg1_r_data_i <  reg2_r_data_i);
      3'b111: br_taken = (reg1_r_data_i >= reg2_r_data_i);
      default: br_taken = 1'b0;
    endcase
  end

`ifdef EX_MUL_EN
  // 33x33 signed product covers all four variants; the extra bit carries
  // each operand's signedness (MULHSU: rs1 signed, rs2 unsigned).
  logic signed [32:0] mul_a, mul_b;
  logic signed [65:0] mul_p;
  logic [31:0] mul_res;
  logic        unused_mul;
  assign mul_a      = $signed({(funct3[1:0] != 2'b11) && op1_i[31], op1_i});
  assign mul_b      = $signed({!funct3[1] && op2_i[31], op2_i});
  assign mul_p      = mul_a * mul_b;
  assign mul_res    = (funct3[1:0] == 2'b00) ? mul_p[31:0] : mul_p[63:32];
  assign unused_mul = ^mul_p[65:64];
`endif

  logic        wb_ena;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  always_comb begin
    wb_ena       = 1'b0;
    wb_addr      = '0;
    wb_data      = '0;
    reg_w_ena_o  = 1'b0;
    reg_w_addr_o = '0;
    reg_w_data_o = '0;
    mem_r_ena_o  = 1'b0;
    mem_w_ena_o  = 1'b0;
    mem_addr_o   = '0;
    mem_w_data_o = '0;
    mem_w_sel_o  = '0;
    jump_ena_o   = 1'b0;
    jump_addr_o  = '0;
    hold_ena_o   = 1'b0;
    if (!rst) begin
      wb_ena      = reg_w_ena_i;
      wb_addr     = reg_w_addr_i;
      mem_r_ena_o = mem_r_ena_i;
      mem_w_ena_o = mem_w_ena_i;
      mem_addr_o  = sum_res;
      case (opcode)
        OPC_OP, OPC_OPIMM:  wb_data = alu_res;
        OPC_LUI, OPC_AUIPC: wb_data = sum_res;
        OPC_JAL: begin
          wb_data     = inst_addr_i + 32'd4;
          jump_ena_o  = 1'b1;
          jump_addr_o = jump_add;
        end
        OPC_JALR: begin
          wb_data     = inst_addr_i + 32'd4;
          jump_ena_o  = 1'b1;
          jump_addr_o = {jump_add[31:1], 1'b0};
        end
        OPC_BRANCH: begin
          jump_ena_o  = br_taken;
          jump_addr_o = br_taken ? jump_add : '0;
        end
        default: wb_data = '0;
      endcase
      if (mem_w_ena_i) begin
        case (funct3)
          3'b000: begin
            mem_w_data_o = {4{reg2_r_data_i[7:0]}};
            mem_w_sel_o  = 4'b0001 << sum_res[1:0];
          end
          3'b001: begin
            mem_w_data_o = {2{reg2_r_data_i[15:0]}};
            mem_w_sel_o  = sum_res[1] ? 4'b1100 : 4'b0011;
          end
          3'b010: begin
            mem_w_data_o = reg2_r_data_i;
            mem_w_sel_o  = 4'b1111;
          end
          default: ;
        endcase
      end
      if (is_mext) begin
        if (div_req) begin
          wb_data = corner_res;
        end else begin
`ifdef EX_MUL_EN
          wb_data = mul_res;
`else
          wb_ena  = 1'b0;
`endif
        end
      end
      // Division priority: issue and CALC suppress write-back and stall;
      // DONE writes the latched rd even though the same DIV is still on inst_i.
      if (div_start || state == S_CALC) begin
        wb_ena     = 1'b0;
        hold_ena_o = 1'b1;
      end
      if (state == S_DONE) begin
        wb_ena  = 1'b1;
        wb_addr = rd_q;
        wb_data = div_res;
      end
      reg_w_ena_o  = wb_ena && (wb_addr != '0);
      reg_w_addr_o = wb_addr;
      reg_w_data_o = wb_data;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{inst_i[24:15], inst_i[11:7], step_diff[32]};

endmodule

// File: tb/tb_ex_stage.sv
module tb_ex_stage;

  logic        clk_100MHz = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] inst_i, inst_addr_i, reg1_r_data_i, reg2_r_data_i;
  logic        reg_w_ena_i, mem_r_ena_i, mem_w_ena_i;
  logic [4:0]  reg_w_addr_i;
  logic [31:0] op1_i, op2_i, op1_jump_i, op2_jump_i;
  logic        reg_w_ena_o, mem_r_ena_o, mem_w_ena_o, jump_ena_o, hold_ena_o;
  logic [4:0]  reg_w_addr_o;
  logic [31:0] reg_w_data_o, mem_addr_o, mem_w_data_o, jump_addr_o;
  logic [3:0]  mem_w_sel_o;

  ex_stage #(.DIV_ITER(32)) dut (
    .clk_100MHz(clk_100MHz), .rst(rst),
    .inst_i(inst_i), .inst_addr_i(inst_addr_i),
    .reg1_r_data_i(reg1_r_data_i), .reg2_r_data_i(reg2_r_data_i),
    .reg_w_ena_i(reg_w_ena_i), .reg_w_addr_i(reg_w_addr_i),
    .mem_r_ena_i(mem_r_ena_i), .mem_w_ena_i(mem_w_ena_i),
    .op1_i(op1_i), .op2_i(op2_i), .op1_jump_i(op1_jump_i), .op2_jump_i(op2_jump_i),
    .reg_w_ena_o(reg_w_ena_o), .reg_w_addr_o(reg_w_addr_o), .reg_w_data_o(reg_w_data_o),
    .mem_r_ena_o(mem_r_ena_o), .mem_w_ena_o(mem_w_ena_o), .mem_addr_o(mem_addr_o),
    .mem_w_data_o(mem_w_data_o), .mem_w_sel_o(mem_w_sel_o),
    .jump_ena_o(jump_ena_o), .jump_addr_o(jump_addr_o), .hold_ena_o(hold_ena_o)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  localparam logic [6:0] OP = 7'b0110011, OPIMM = 7'b0010011, BR = 7'b1100011;
  localparam logic [6:0] JAL = 7'b1101111, JALR = 7'b1100111, ST = 7'b0100011;

  typedef struct {
    string       nm;
    bit          c_zero, c_we, c_wd, c_jmp, c_hold, c_mem;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        je;
    logic [31:0] ja;
    logic        ho;
    logic [3:0]  sel;
    logic [31:0] md;
    logic [31:0] ma;
  } exp_t;

  exp_t sbq[$];
  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3,
                                     input logic [6:0] opc);
    return {f7, 10'd0, f3, 5'd0, opc};
  endfunction

  function automatic exp_t e0(input string nm);
    exp_t e;
    e.nm = nm;
    e.c_zero = 0; e.c_we = 0; e.c_wd = 0; e.c_jmp = 0; e.c_hold = 0; e.c_mem = 0;
    e.we = 0; e.wa = '0; e.wd = '0; e.je = 0; e.ja = '0; e.ho = 0;
    e.sel = '0; e.md = '0; e.ma = '0;
    return e;
  endfunction

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: the DUT presents a result every cycle, so one expectation is
  // consumed per falling edge.
  always @(negedge clk_100MHz) begin : mon
    exp_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      if (e.c_zero)
        cmp({e.nm, "_allzero"}, 32'($countones({reg_w_ena_o, reg_w_addr_o, reg_w_data_o,
            mem_r_ena_o, mem_w_ena_o, mem_addr_o, mem_w_data_o, mem_w_sel_o,
            jump_ena_o, jump_addr_o, hold_ena_o})), 32'd0);
      if (e.c_we)   cmp({e.nm, "_we"}, {31'd0, reg_w_ena_o}, {31'd0, e.we});
      if (e.c_wd) begin
        cmp({e.nm, "_wa"}, {27'd0, reg_w_addr_o}, {27'd0, e.wa});
        cmp({e.nm, "_wd"}, reg_w_data_o, e.wd);
      end
      if (e.c_jmp) begin
        cmp({e.nm, "_je"}, {31'd0, jump_ena_o}, {31'd0, e.je});
        cmp({e.nm, "_ja"}, jump_addr_o, e.ja);
      end
      if (e.c_hold) cmp({e.nm, "_hold"}, {31'd0, hold_ena_o}, {31'd0, e.ho});
      if (e.c_mem) begin
        cmp({e.nm, "_sel"}, {28'd0, mem_w_sel_o}, {28'd0, e.sel});
        cmp({e.nm, "_mdata"}, mem_w_data_o, e.md);
        cmp({e.nm, "_maddr"}, mem_addr_o, e.ma);
      end
      cmp({e.nm, "_jump_hold_excl"}, {31'd0, jump_ena_o & hold_ena_o}, 32'd0);
    end
  end

  task automatic step(input exp_t e);
    sbq.push_back(e);
    @(posedge clk_100MHz);
    #1;
  endtask

  task automatic nop();
    inst_i = 32'h0000_0013; inst_addr_i = '0;
    reg1_r_data_i = '0; reg2_r_data_i = '0;
    reg_w_ena_i = 0; reg_w_addr_i = '0; mem_r_ena_i = 0; mem_w_ena_i = 0;
    op1_i = '0; op2_i = '0; op1_jump_i = '0; op2_jump_i = '0;
  endtask

  task automatic alu(input string nm, input logic [31:0] inst, input logic [31:0] a,
                     input logic [31:0] b, input logic [4:0] rd,
                     input logic ew, input logic [31:0] res);
    exp_t e;
    nop();
    inst_i = inst; op1_i = a; op2_i = b; reg1_r_data_i = a; reg2_r_data_i = b;
    reg_w_ena_i = 1; reg_w_addr_i = rd;
    e = e0(nm);
    e.c_we = 1; e.we = ew; e.c_hold = 1; e.ho = 0;
    if (ew) begin e.c_wd = 1; e.wa = rd; e.wd = res; end
    step(e);
  endtask

  task automatic branch(input string nm, input logic [2:0] f3, input logic [31:0] r1,
                        input logic [31:0] r2, input logic [31:0] j1,
                        input logic [31:0] j2, input logic ej, input logic [31:0] ea);
    exp_t e;
    nop();
    inst_i = mk(7'd0, f3, BR); reg1_r_data_i = r1; reg2_r_data_i = r2;
    op1_jump_i = j1; op2_jump_i = j2;
    e = e0(nm);
    e.c_jmp = 1; e.je = ej; e.ja = ea; e.c_we = 1; e.we = 0;
    step(e);
  endtask

  task automatic store(input string nm, input logic [2:0] f3, input logic [31:0] base,
                       input logic [31:0] off, input logic [31:0] r2,
                       input logic [3:0] esel, input logic [31:0] edata);
    exp_t e;
    nop();
    inst_i = mk(7'd0, f3, ST); op1_i = base; op2_i = off; reg2_r_data_i = r2;
    mem_w_ena_i = 1;
    e = e0(nm);
    e.c_mem = 1; e.sel = esel; e.md = edata; e.ma = base + off;
    e.c_we = 1; e.we = 0; e.c_jmp = 1;
    step(e);
  endtask

  task automatic div_setup(input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] rd);
    nop();
    inst_i = mk(7'b0000001, f3, OP); op1_i = a; op2_i = b;
    reg1_r_data_i = a; reg2_r_data_i = b; reg_w_ena_i = 1; reg_w_addr_i = rd;
  endtask

  task automatic div_run(input string nm, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd,
                         input logic [31:0] res);
    exp_t e;
    div_setup(f3, a, b, rd);
    for (int unsigned k = 1; k <= 33; k++) begin
      e = e0({nm, "_busy"});
      e.c_hold = 1; e.ho = 1; e.c_we = 1; e.we = 0; e.c_jmp = 1;
      step(e);
    end
    e = e0(nm);
    e.c_hold = 1; e.ho = 0; e.c_we = 1; e.we = 1; e.c_wd = 1; e.wa = rd; e.wd = res;
    step(e);
    nop();
  endtask

  task automatic div_corner(input string nm, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] b, input logic [4:0] rd,
                            input logic [31:0] res);
    exp_t e;
    div_setup(f3, a, b, rd);
    e = e0(nm);
    e.c_hold = 1; e.ho = 0; e.c_we = 1; e.we = 1; e.c_wd = 1; e.wa = rd; e.wd = res;
    step(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : drv
    exp_t e;
    nop();
    rst = 1;
    @(posedge clk_100MHz);
    #1;
    // Outputs must be gated to zero while rst is high, even with live inputs
    inst_i = mk(7'd0, 3'b000, OP); op1_i = 5; op2_i = 7; reg_w_ena_i = 1; reg_w_addr_i = 3;
    op1_jump_i = 32'h100; mem_w_ena_i = 1; mem_r_ena_i = 1;
    e = e0("reset"); e.c_zero = 1;
    step(e);
    rst = 0;

    alu("add",    mk(7'd0, 3'b000, OP), 32'd5, 32'd7, 5'd3, 1'b1, 32'd12);
    alu("sub",    mk(7'b0100000, 3'b000, OP), 32'd5, 32'd7, 5'd4, 1'b1, 32'hFFFF_FFFE);
    alu("sltu",   mk(7'd0, 3'b011, OP), 32'd1, 32'hFFFF_FFFF, 5'd4, 1'b1, 32'd1);
    alu("slt",    mk(7'd0, 3'b010, OP), 32'd1, 32'hFFFF_FFFF, 5'd4, 1'b1, 32'd0);
    alu("srai",   mk(7'b0100000, 3'b101, OPIMM), 32'h8000_0000, 32'd4, 5'd9, 1'b1, 32'hF800_0000);
    alu("srl",    mk(7'd0, 3'b101, OP), 32'h8000_0000, 32'd36, 5'd9, 1'b1, 32'h0800_0000);
    alu("add_x0", mk(7'd0, 3'b000, OP), 32'd1, 32'd1, 5'd0, 1'b0, 32'd0);
`ifdef EX_MUL_EN
    alu("mul",    mk(7'b0000001, 3'b000, OP), 32'd5, 32'd7, 5'd8, 1'b1, 32'd35);
`else
    alu("mul",    mk(7'b0000001, 3'b000, OP), 32'd5, 32'd7, 5'd8, 1'b0, 32'd0);
`endif

    branch("beq_t",  3'b000, 32'd9, 32'd9, 32'h100, 32'h20, 1'b1, 32'h120);
    branch("beq_nt", 3'b000, 32'd9, 32'd8, 32'h100, 32'h20, 1'b0, 32'h0);
    branch("blt_t",  3'b100, 32'hFFFF_FFFF, 32'd1, 32'h100, 32'h8, 1'b1, 32'h108);
    branch("bltu_nt",3'b110, 32'hFFFF_FFFF, 32'd1, 32'h100, 32'h8, 1'b0, 32'h0);

    nop();
    inst_i = mk(7'd0, 3'b000, JALR); inst_addr_i = 32'h200;
    op1_jump_i = 32'h301; op2_jump_i = 32'h10; reg_w_ena_i = 1; reg_w_addr_i = 1;
    e = e0("jalr");
    e.c_jmp = 1; e.je = 1; e.ja = 32'h310; e.c_we = 1; e.we = 1; e.c_wd = 1;
    e.wa = 1; e.wd = 32'h204; e.c_hold = 1; e.ho = 0;
    step(e);

    nop();
    inst_i = {25'd0, JAL}; inst_addr_i = 32'h400;
    op1_jump_i = 32'h400; op2_jump_i = 32'h80; reg_w_ena_i = 1; reg_w_addr_i = 2;
    e = e0("jal");
    e.c_jmp = 1; e.je = 1; e.ja = 32'h480; e.c_we = 1; e.we = 1; e.c_wd = 1;
    e.wa = 2; e.wd = 32'h404;
    step(e);

    store("sb", 3'b000, 32'h1000, 32'd3, 32'h0000_00AB, 4'b1000, 32'hABAB_ABAB);
    store("sb0",3'b000, 32'h1000, 32'd0, 32'h1234_5601, 4'b0001, 32'h0101_0101);
    store("sh", 3'b001, 32'h1000, 32'd2, 32'h0000_BEEF, 4'b1100, 32'hBEEF_BEEF);
    store("sw", 3'b010, 32'h2000, 32'd4, 32'h1234_5678, 4'b1111, 32'h1234_5678);

    div_run("div",  3'b100, 32'hFFFF_FFF9, 32'd2, 5'd5, 32'hFFFF_FFFD);
    div_run("rem",  3'b110, 32'hFFFF_FFF9, 32'd2, 5'd5, 32'hFFFF_FFFF);

    div_corner("divu_by0", 3'b101, 32'h1234, 32'd0, 5'd6, 32'hFFFF_FFFF);
    div_corner("remu_by0", 3'b111, 32'h1234, 32'd0, 5'd6, 32'h1234);
    div_corner("div_ovf",  3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6, 32'h8000_0000);
    div_corner("rem_ovf",  3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6, 32'd0);

    // Reset during CALC: issue, 9 CALC cycles, reset on the 10th
    div_setup(3'b101, 32'd100, 32'd3, 5'd7);
    for (int unsigned k = 0; k < 10; k++) begin
      e = e0("divu_pre_rst");
      e.c_hold = 1; e.ho = 1; e.c_we = 1; e.we = 0;
      step(e);
    end
    rst = 1;
    e = e0("rst_mid_div"); e.c_zero = 1;
    step(e);
    rst = 0;
    nop();
    e = e0("after_rst"); e.c_zero = 1;
    step(e);
    div_run("divu_rerun", 3'b101, 32'd100, 32'd3, 5'd7, 32'd33);

    nop();
    e = e0("idle_after_div"); e.c_hold = 1; e.ho = 0; e.c_we = 1; e.we = 0;
    step(e);
    @(posedge clk_100MHz);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
